// File: rtl/mem_arbiter_if.sv
// Shared bus bundle between the memory arbiter, its two requesters (ICache, LSB) and the RAM/IO pins.
// The master modport is the arbiter's view; slave is the requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_ready;
  logic [31:0]       ic_data;

  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_done;
  logic [31:0]       ls_rdata;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport master (
    input  ic_req, ic_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    input  mem_din, io_buffer_full,
    output ic_ready, ic_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport slave (
    output ic_req, ic_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    output mem_din, io_buffer_full,
    input  ic_ready, ic_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin byte-serial arbiter: ICache/LSB requests become N byte bus cycles; reads done at T+2+N, writes at T+1+N.
// Backpressure: rdy_in low freezes everything; io_buffer_full stalls IO-region write bytes in place.
module mem_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          clear_flag,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, IC_RD, LS_RD, LS_WR} state_t;

  state_t            state_q, state_nxt;
  logic              last_ls_q, last_ls_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [ADDR_W-1:0] mem_a_q, mem_a_nxt;
  logic [31:0]       wdata_q, wdata_nxt;
  logic [31:0]       buf_q, buf_nxt;
  logic [31:0]       ic_data_q, ic_data_nxt;
  logic [31:0]       ls_rdata_q, ls_rdata_nxt;
  logic [2:0]        len_q, len_nxt;
  logic [2:0]        cnt_q, cnt_nxt;
  logic [7:0]        dout_q, dout_nxt;
  logic              wr_q, wr_nxt;
  logic              ic_ready_q, ic_ready_nxt;
  logic              ls_done_q, ls_done_nxt;

  logic [2:0]        cnt_inc, cnt_dec, ls_len;
  logic [ADDR_W-1:0] addr_off;
  logic              is_io, io_stall, grant_ok, pick_ic, pick_ls;

  assign cnt_inc  = cnt_q + 3'd1;
  assign cnt_dec  = cnt_q - 3'd1;
  assign addr_off = addr_q + {{(ADDR_W-3){1'b0}}, cnt_inc};
  assign is_io    = (addr_q[17:16] == IO_HI);
  assign io_stall = (state_q == LS_WR) && is_io && bus.io_buffer_full;

  // A done pulse in flight blocks the grant so the finishing requester can drop req first.
  assign grant_ok = !ic_ready_q && !ls_done_q && !clear_flag;
  assign pick_ic  = bus.ic_req && (!bus.ls_req || last_ls_q);
  assign pick_ls  = bus.ls_req && (!bus.ic_req || !last_ls_q);

  always_comb begin
    case (bus.ls_size)
      2'd0:    ls_len = 3'd1;
      2'd1:    ls_len = 3'd2;
      default: ls_len = 3'd4;
    endcase
  end

  always_comb begin
    state_nxt    = state_q;
    last_ls_nxt  = last_ls_q;
    addr_nxt     = addr_q;
    mem_a_nxt    = mem_a_q;
    wdata_nxt    = wdata_q;
    buf_nxt      = buf_q;
    ic_data_nxt  = ic_data_q;
    ls_rdata_nxt = ls_rdata_q;
    len_nxt      = len_q;
    cnt_nxt      = cnt_q;
    dout_nxt     = dout_q;
    wr_nxt       = wr_q;
    ic_ready_nxt = 1'b0;
    ls_done_nxt  = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_ok && (pick_ic || pick_ls)) begin
          cnt_nxt = 3'd0;
          buf_nxt = 32'd0;
          // Round-robin pointer only moves on a contested grant.
          if (bus.ic_req && bus.ls_req) last_ls_nxt = pick_ls;
          if (pick_ic) begin
            state_nxt = IC_RD;
            addr_nxt  = bus.ic_addr;
            mem_a_nxt = bus.ic_addr;
            len_nxt   = 3'd4;
          end else begin
            addr_nxt  = bus.ls_addr;
            mem_a_nxt = bus.ls_addr;
            len_nxt   = ls_len;
            wdata_nxt = bus.ls_wdata;
            if (bus.ls_we) begin
              state_nxt = LS_WR;
              wr_nxt    = 1'b1;
              dout_nxt  = bus.ls_wdata[7:0];
            end else begin
              state_nxt = LS_RD;
            end
          end
        end
      end

      IC_RD, LS_RD: begin
        if (clear_flag) begin
          state_nxt = IDLE;
          mem_a_nxt = '0;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc < len_q) mem_a_nxt = addr_off;
          // mem_din lags mem_a by one cycle, so the byte arriving now belongs to cnt-1.
          if (cnt_q != 3'd0) buf_nxt[{cnt_dec[1:0], 3'b000} +: 8] = bus.mem_din;
          if (cnt_q == len_q) begin
            state_nxt = IDLE;
            mem_a_nxt = '0;
            if (state_q == IC_RD) begin
              ic_ready_nxt = 1'b1;
              ic_data_nxt  = buf_nxt;
            end else begin
              ls_done_nxt  = 1'b1;
              ls_rdata_nxt = buf_nxt;
            end
          end
        end
      end

      LS_WR: begin
        if (!io_stall) begin
          if (cnt_inc < len_q) begin
            cnt_nxt   = cnt_inc;
            mem_a_nxt = addr_off;
            dout_nxt  = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
          end else begin
            state_nxt   = IDLE;
            wr_nxt      = 1'b0;
            mem_a_nxt   = '0;
            ls_done_nxt = 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      last_ls_q  <= 1'b1;
      addr_q     <= '0;
      mem_a_q    <= '0;
      wdata_q    <= 32'd0;
      buf_q      <= 32'd0;
      ic_data_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
      len_q      <= 3'd0;
      cnt_q      <= 3'd0;
      dout_q     <= 8'd0;
      wr_q       <= 1'b0;
      ic_ready_q <= 1'b0;
      ls_done_q  <= 1'b0;
    end else if (rdy_in) begin
      state_q    <= state_nxt;
      last_ls_q  <= last_ls_nxt;
      addr_q     <= addr_nxt;
      mem_a_q    <= mem_a_nxt;
      wdata_q    <= wdata_nxt;
      buf_q      <= buf_nxt;
      ic_data_q  <= ic_data_nxt;
      ls_rdata_q <= ls_rdata_nxt;
      len_q      <= len_nxt;
      cnt_q      <= cnt_nxt;
      dout_q     <= dout_nxt;
      wr_q       <= wr_nxt;
      ic_ready_q <= ic_ready_nxt;
      ls_done_q  <= ls_done_nxt;
    end
  end

  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = dout_q;
  assign bus.mem_wr   = wr_q & rdy_in & !io_stall;
  assign bus.ic_ready = ic_ready_q;
  assign bus.ic_data  = ic_data_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-exact checks of grant order, byte timing, IO stall, flush and freeze.
// Cycle k of a scenario is k clocks after the grant cycle T; inputs change at posedge+1, outputs sampled at posedge+2.
module tb_mem_arbiter;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear_flag;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_in = ~clk_in;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear_flag (clear_flag),
    .bus        (bus)
  );

  // Synchronous RAM sharing the core enable: registered read, write on mem_wr.
  logic [7:0] ram [0:262143];
  logic [7:0] din_q = 8'd0;
  logic       ram_init = 1'b0;
  int         wr_cnt = 0;
  assign bus.mem_din = din_q;

  always @(posedge clk_in) begin
    if (!ram_init) begin
      ram[18'h00100] = 8'h13; ram[18'h00101] = 8'h00; ram[18'h00102] = 8'h00; ram[18'h00103] = 8'h00;
      ram[18'h00200] = 8'h11; ram[18'h00201] = 8'h22; ram[18'h00202] = 8'h33; ram[18'h00203] = 8'h44;
      ram[18'h00301] = 8'h00; ram[18'h00302] = 8'h00; ram[18'h00303] = 8'h77;
      ram[18'h00310] = 8'h00; ram[18'h00311] = 8'h00; ram[18'h00312] = 8'h00; ram[18'h00313] = 8'h00;
      ram[18'h30000] = 8'h00;
      ram_init = 1'b1;
    end
    if (rdy_in) begin
      din_q <= ram[bus.mem_a[17:0]];
      if (bus.mem_wr) begin
        ram[bus.mem_a[17:0]] = bus.mem_dout;
        wr_cnt = wr_cnt + 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    bus.ic_req = 1'b0;
    bus.ls_req = 1'b0;
    clear_flag = 1'b0;
    bus.io_buffer_full = 1'b0;
    rdy_in = 1'b1;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    idle(3);
    #1;
    total += 7;
    if (bus.mem_a !== 32'd0)    begin bad++; $display("FAIL reset_mem_a got=%h exp=0", bus.mem_a); end
    if (bus.mem_dout !== 8'd0)  begin bad++; $display("FAIL reset_mem_dout got=%h exp=0", bus.mem_dout); end
    if (bus.mem_wr !== 1'b0)    begin bad++; $display("FAIL reset_mem_wr got=%b exp=0", bus.mem_wr); end
    if (bus.ic_ready !== 1'b0)  begin bad++; $display("FAIL reset_ic_ready got=%b exp=0", bus.ic_ready); end
    if (bus.ls_done !== 1'b0)   begin bad++; $display("FAIL reset_ls_done got=%b exp=0", bus.ls_done); end
    if (bus.ic_data !== 32'd0)  begin bad++; $display("FAIL reset_ic_data got=%h exp=0", bus.ic_data); end
    if (bus.ls_rdata !== 32'd0) begin bad++; $display("FAIL reset_ls_rdata got=%h exp=0", bus.ls_rdata); end
    rst_in = 1'b0;
    idle(1);
  endtask

  task automatic test_ic_read();
    logic [31:0] exp_a;
    bus.ic_req = 1'b1; bus.ic_addr = 32'h100;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      if (k == 7) bus.ic_req = 1'b0;
      #1;
      if (k <= 4) begin
        exp_a = 32'h100 + k - 1;
        total += 2;
        if (bus.mem_a !== exp_a) begin bad++; $display("FAIL ic_rd_addr k=%0d got=%h exp=%h", k, bus.mem_a, exp_a); end
        if (bus.mem_wr !== 1'b0) begin bad++; $display("FAIL ic_rd_wr k=%0d got=%b exp=0", k, bus.mem_wr); end
      end
      if (k == 5 || k == 7) begin
        total++;
        if (bus.ic_ready !== 1'b0) begin bad++; $display("FAIL ic_rd_early k=%0d got=%b exp=0", k, bus.ic_ready); end
      end
      if (k == 6) begin
        total += 2;
        if (bus.ic_ready !== 1'b1)       begin bad++; $display("FAIL ic_rd_ready got=%b exp=1", bus.ic_ready); end
        if (bus.ic_data !== 32'h00000013) begin bad++; $display("FAIL ic_rd_data got=%h exp=00000013", bus.ic_data); end
      end
    end
    idle(2);
  endtask

  task automatic test_arbitration();
    bus.ic_req = 1'b1; bus.ic_addr = 32'h100;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd2; bus.ls_addr = 32'h200;
    for (int k = 1; k <= 29; k++) begin
      cyc();
      if (k == 7)  bus.ic_req = 1'b0;
      if (k == 14) bus.ls_req = 1'b0;
      if (k == 15) begin bus.ic_req = 1'b1; bus.ls_req = 1'b1; end
      if (k == 22) bus.ls_req = 1'b0;
      if (k == 29) bus.ic_req = 1'b0;
      #1;
      if (k == 1) begin
        total++;
        if (bus.mem_a !== 32'h100) begin bad++; $display("FAIL arb_first_ic got=%h exp=00000100", bus.mem_a); end
      end
      if (k == 6) begin
        total += 3;
        if (bus.ic_ready !== 1'b1)       begin bad++; $display("FAIL arb_ic_ready got=%b exp=1", bus.ic_ready); end
        if (bus.ic_data !== 32'h00000013) begin bad++; $display("FAIL arb_ic_data got=%h exp=00000013", bus.ic_data); end
        if (bus.ls_done !== 1'b0)        begin bad++; $display("FAIL arb_ls_early got=%b exp=0", bus.ls_done); end
      end
      if (k == 8) begin
        total++;
        if (bus.mem_a !== 32'h200) begin bad++; $display("FAIL arb_ls_second got=%h exp=00000200", bus.mem_a); end
      end
      if (k == 12) begin
        total++;
        if (bus.ls_done !== 1'b0) begin bad++; $display("FAIL arb_ls_done_early got=%b exp=0", bus.ls_done); end
      end
      if (k == 13) begin
        total += 2;
        if (bus.ls_done !== 1'b1)         begin bad++; $display("FAIL arb_ls_done got=%b exp=1", bus.ls_done); end
        if (bus.ls_rdata !== 32'h44332211) begin bad++; $display("FAIL arb_ls_rdata got=%h exp=44332211", bus.ls_rdata); end
      end
      if (k == 16) begin
        total++;
        if (bus.mem_a !== 32'h200) begin bad++; $display("FAIL arb_third_ls_first got=%h exp=00000200", bus.mem_a); end
      end
      if (k == 21) begin
        total++;
        if (bus.ls_done !== 1'b1) begin bad++; $display("FAIL arb_third_ls_done got=%b exp=1", bus.ls_done); end
      end
      if (k == 23) begin
        total++;
        if (bus.mem_a !== 32'h100) begin bad++; $display("FAIL arb_third_ic_addr got=%h exp=00000100", bus.mem_a); end
      end
      if (k == 28) begin
        total++;
        if (bus.ic_ready !== 1'b1) begin bad++; $display("FAIL arb_third_ic_ready got=%b exp=1", bus.ic_ready); end
      end
    end
    idle(2);
  endtask

  task automatic test_half_store();
    int w0;
    w0 = wr_cnt;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'd1; bus.ls_addr = 32'h301; bus.ls_wdata = 32'hAABBCCDD;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (k == 4) bus.ls_req = 1'b0;
      #1;
      if (k == 1) begin
        total += 3;
        if (bus.mem_a !== 32'h301)  begin bad++; $display("FAIL hs_addr0 got=%h exp=00000301", bus.mem_a); end
        if (bus.mem_dout !== 8'hDD) begin bad++; $display("FAIL hs_dout0 got=%h exp=dd", bus.mem_dout); end
        if (bus.mem_wr !== 1'b1)    begin bad++; $display("FAIL hs_wr0 got=%b exp=1", bus.mem_wr); end
      end
      if (k == 2) begin
        total += 4;
        if (bus.mem_a !== 32'h302)  begin bad++; $display("FAIL hs_addr1 got=%h exp=00000302", bus.mem_a); end
        if (bus.mem_dout !== 8'hCC) begin bad++; $display("FAIL hs_dout1 got=%h exp=cc", bus.mem_dout); end
        if (bus.mem_wr !== 1'b1)    begin bad++; $display("FAIL hs_wr1 got=%b exp=1", bus.mem_wr); end
        if (bus.ls_done !== 1'b0)   begin bad++; $display("FAIL hs_done_early got=%b exp=0", bus.ls_done); end
      end
      if (k == 3) begin
        total += 3;
        if (bus.ls_done !== 1'b1) begin bad++; $display("FAIL hs_done got=%b exp=1", bus.ls_done); end
        if (bus.mem_wr !== 1'b0)  begin bad++; $display("FAIL hs_wr_end got=%b exp=0", bus.mem_wr); end
        if (bus.mem_a !== 32'd0)  begin bad++; $display("FAIL hs_addr_end got=%h exp=0", bus.mem_a); end
      end
    end
    total += 4;
    if (ram[18'h301] !== 8'hDD) begin bad++; $display("FAIL hs_ram301 got=%h exp=dd", ram[18'h301]); end
    if (ram[18'h302] !== 8'hCC) begin bad++; $display("FAIL hs_ram302 got=%h exp=cc", ram[18'h302]); end
    if (ram[18'h303] !== 8'h77) begin bad++; $display("FAIL hs_ram303 got=%h exp=77", ram[18'h303]); end
    if (wr_cnt - w0 !== 2)      begin bad++; $display("FAIL hs_wr_count got=%0d exp=2", wr_cnt - w0); end
    idle(2);
  endtask

  task automatic test_io_store();
    int w0;
    w0 = wr_cnt;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'd0; bus.ls_addr = 32'h30000; bus.ls_wdata = 32'h0000005A;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      bus.io_buffer_full = (k <= 3);
      if (k == 6) bus.ls_req = 1'b0;
      #1;
      if (k <= 3) begin
        total += 3;
        if (bus.mem_wr !== 1'b0)     begin bad++; $display("FAIL io_stall_wr k=%0d got=%b exp=0", k, bus.mem_wr); end
        if (bus.mem_a !== 32'h30000) begin bad++; $display("FAIL io_stall_addr k=%0d got=%h exp=00030000", k, bus.mem_a); end
        if (bus.ls_done !== 1'b0)    begin bad++; $display("FAIL io_stall_done k=%0d got=%b exp=0", k, bus.ls_done); end
      end
      if (k == 4) begin
        total += 3;
        if (bus.mem_wr !== 1'b1)    begin bad++; $display("FAIL io_wr got=%b exp=1", bus.mem_wr); end
        if (bus.mem_dout !== 8'h5A) begin bad++; $display("FAIL io_dout got=%h exp=5a", bus.mem_dout); end
        if (bus.ls_done !== 1'b0)   begin bad++; $display("FAIL io_done_early got=%b exp=0", bus.ls_done); end
      end
      if (k == 5) begin
        total++;
        if (bus.ls_done !== 1'b1) begin bad++; $display("FAIL io_done got=%b exp=1", bus.ls_done); end
      end
    end
    total += 2;
    if (ram[18'h30000] !== 8'h5A) begin bad++; $display("FAIL io_ram got=%h exp=5a", ram[18'h30000]); end
    if (wr_cnt - w0 !== 1)        begin bad++; $display("FAIL io_wr_count got=%0d exp=1", wr_cnt - w0); end
    idle(2);
  endtask

  task automatic test_flush();
    logic [31:0] word;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd2; bus.ls_addr = 32'h200;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (k == 4) clear_flag = 1'b1;
      if (k == 5) begin clear_flag = 1'b0; bus.ls_req = 1'b0; end
      #1;
      total++;
      if (bus.ls_done !== 1'b0) begin bad++; $display("FAIL fl_rd_no_done k=%0d got=%b exp=0", k, bus.ls_done); end
      if (k == 5) begin
        total += 2;
        if (bus.mem_a !== 32'd0) begin bad++; $display("FAIL fl_rd_idle_addr got=%h exp=0", bus.mem_a); end
        if (bus.mem_wr !== 1'b0) begin bad++; $display("FAIL fl_rd_idle_wr got=%b exp=0", bus.mem_wr); end
      end
    end
    idle(1);
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'd2; bus.ls_addr = 32'h310; bus.ls_wdata = 32'h01020304;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 2) clear_flag = 1'b1;
      if (k == 3) clear_flag = 1'b0;
      if (k == 6) bus.ls_req = 1'b0;
      #1;
      if (k == 2) begin
        total += 2;
        if (bus.mem_wr !== 1'b1)    begin bad++; $display("FAIL fl_wr_on got=%b exp=1", bus.mem_wr); end
        if (bus.mem_dout !== 8'h03) begin bad++; $display("FAIL fl_wr_dout got=%h exp=03", bus.mem_dout); end
      end
      if (k == 5) begin
        total++;
        if (bus.ls_done !== 1'b1) begin bad++; $display("FAIL fl_wr_done got=%b exp=1", bus.ls_done); end
      end
    end
    word = {ram[18'h313], ram[18'h312], ram[18'h311], ram[18'h310]};
    total++;
    if (word !== 32'h01020304) begin bad++; $display("FAIL fl_wr_ram got=%h exp=01020304", word); end
    idle(2);
  endtask

  task automatic test_freeze();
    bus.ic_req = 1'b1; bus.ic_addr = 32'h200;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (k == 3) rdy_in = 1'b0;
      if (k == 5) rdy_in = 1'b1;
      if (k == 9) bus.ic_req = 1'b0;
      #1;
      if (k >= 3 && k <= 5) begin
        total++;
        if (bus.mem_a !== 32'h202) begin bad++; $display("FAIL fz_hold_addr k=%0d got=%h exp=00000202", k, bus.mem_a); end
      end
      if (k == 3 || k == 4) begin
        total++;
        if (bus.mem_wr !== 1'b0) begin bad++; $display("FAIL fz_wr k=%0d got=%b exp=0", k, bus.mem_wr); end
      end
      if (k == 6) begin
        total++;
        if (bus.mem_a !== 32'h203) begin bad++; $display("FAIL fz_resume_addr got=%h exp=00000203", bus.mem_a); end
      end
      if (k == 6 || k == 7) begin
        total++;
        if (bus.ic_ready !== 1'b0) begin bad++; $display("FAIL fz_ready_early k=%0d got=%b exp=0", k, bus.ic_ready); end
      end
      if (k == 8) begin
        total += 2;
        if (bus.ic_ready !== 1'b1)       begin bad++; $display("FAIL fz_ready got=%b exp=1", bus.ic_ready); end
        if (bus.ic_data !== 32'h44332211) begin bad++; $display("FAIL fz_data got=%h exp=44332211", bus.ic_data); end
      end
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    bus.ic_req = 1'b1; bus.ic_addr = 32'h100;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 2) rst_in = 1'b1;
      if (k == 3) begin rst_in = 1'b0; bus.ic_req = 1'b0; end
      #1;
      if (k == 3) begin
        total++;
        if (bus.mem_a !== 32'd0) begin bad++; $display("FAIL rm_addr got=%h exp=0", bus.mem_a); end
      end
      if (k >= 3) begin
        total++;
        if (bus.ic_ready !== 1'b0) begin bad++; $display("FAIL rm_no_ready k=%0d got=%b exp=0", k, bus.ic_ready); end
      end
    end
    idle(2);
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    clear_flag = 1'b0;
    bus.ic_req = 1'b0; bus.ic_addr = 32'd0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = 2'd0; bus.ls_addr = 32'd0; bus.ls_wdata = 32'd0;
    bus.io_buffer_full = 1'b0;
    test_reset();
    test_ic_read();
    test_arbitration();
    test_half_store();
    test_io_store();
    test_flush();
    test_freeze();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
